// File: rtl/boot_pkg.sv
// Shared types and stream-format constants for the boot loader.
// The image layout is a byte count, little-endian payload words, then an XOR checksum byte.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } boot_state_e;

    localparam int COUNT_BYTES    = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_BYTES     = 1;

    // Total stream length in bytes for an image of n words.
    function automatic int image_bytes(input int n);
        return COUNT_BYTES + BYTES_PER_WORD * n + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs payload bytes into a little-endian 32-bit word and keeps a running XOR of every byte loaded.
// The accumulator spans the whole image; clear only restarts the lane index for the next word.
module byte_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  data_byte,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  checksum
);

    logic [1:0]  lane;
    logic [31:0] word_q;
    logic [7:0]  acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane   <= '0;
            word_q <= '0;
            acc    <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (load) begin
            word_q[{lane, 3'b000} +: 8] <= data_byte;
            lane                        <= lane + 2'd1;
            acc                         <= acc ^ data_byte;
        end
    end

    // Flags that the next load completes the word.
    assign word_full = (lane == 2'(BYTES_PER_WORD - 1));
    assign word      = word_q;
    assign checksum  = acc;

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-protected image into memory and holds the core in reset until it
// has been received in full and the checksum matches.
module boot_loader
    import boot_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 CNT_W     = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  words_written
);

    boot_state_e       state, state_nxt;
    logic              xfer;
    logic [7:0]        n_lo;
    logic [15:0]       n_rx;
    logic [CNT_W-1:0]  n_total;
    logic [CNT_W-1:0]  ww;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       last_wdata;
    logic [31:0]       asm_word;
    logic              asm_full;
    logic [7:0]        asm_csum;

    assign xfer    = rx_valid & rx_ready;
    assign n_rx    = {rx_data, n_lo};
    assign wr_addr = BASE_ADDR + (ADDR_W'(ww) << 2);

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .load      ((state == DATA) && xfer),
        .data_byte (rx_data),
        .clear     (state == WRITE),
        .word      (asm_word),
        .word_full (asm_full),
        .checksum  (asm_csum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LEN0;
            n_lo       <= '0;
            n_total    <= '0;
            ww         <= '0;
            last_addr  <= BASE_ADDR;
            last_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == LEN0 && xfer) n_lo <= rx_data;
            if (state == LEN1 && xfer) n_total <= CNT_W'(n_rx);
            if (state == WRITE) begin
                ww         <= ww + 1'b1;
                last_addr  <= wr_addr;
                last_wdata <= asm_word;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LEN0:    if (xfer) state_nxt = LEN1;
            LEN1:    if (xfer) state_nxt = (n_rx == 16'd0) ? CSUM : DATA;
            DATA:    if (xfer && asm_full) state_nxt = WRITE;
            // ww never reaches 2^CNT_W-1 here, so the increment cannot wrap before the compare.
            WRITE:   state_nxt = (ww + 1'b1 == n_total) ? CSUM : DATA;
            CSUM:    if (xfer) state_nxt = (rx_data == asm_csum) ? DONE : ERROR;
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = LEN0;
        endcase
    end

    // Control outputs are registered from the next state so they never depend on rx_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ready  <= 1'b1;
            mem_we    <= 1'b0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rx_ready  <= state_nxt inside {LEN0, LEN1, DATA, CSUM};
            mem_we    <= (state_nxt == WRITE);
            core_hold <= (state_nxt != DONE);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERROR);
        end
    end

    // Outside the write cycle the port shows the last written address and word.
    assign mem_addr      = mem_we ? wr_addr : last_addr;
    assign mem_wdata     = mem_we ? asm_word : last_wdata;
    assign words_written = ww;

endmodule
